// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit of the pipelined MIPS.
package mips_mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // StHi is the second beat of a halfword access (byte at addr+1).
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHi   = 1'b1
    } lsu_state_e;

    // Widen a loaded byte to a halfword, sign- or zero-extended.
    function automatic logic [2*DATA_W-1:0] extend_byte(input logic [DATA_W-1:0] b,
                                                        input logic             is_signed);
        return {{DATA_W{b[DATA_W-1] & is_signed}}, b};
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the byte-wide data memory. Byte ops complete in one cycle;
// halfword ops are split into a low-byte beat (stalling the pipeline) and a high-byte beat.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = mips_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = mips_mem_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic                  req_half,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [2*DATA_W-1:0]   ld_data,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    lsu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0]   hi_wdata_q, hi_wdata_d;
    logic                hi_write_q, hi_write_d;
    logic [DATA_W-1:0]   lo_byte_q, lo_byte_d;
    logic                ld_valid_q, ld_valid_d;
    logic [2*DATA_W-1:0] ld_data_q, ld_data_d;

    // Next-state, memory-port drive and load-result formation.
    always_comb begin
        state_d    = state_q;
        hi_addr_d  = hi_addr_q;
        hi_wdata_d = hi_wdata_q;
        hi_write_d = hi_write_q;
        lo_byte_d  = lo_byte_q;
        ld_valid_d = 1'b0;
        ld_data_d  = ld_data_q;
        stall      = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // First (or only) beat always targets req_addr.
                    mem_addr = req_addr;
                    if (req_write) begin
                        mem_write = 1'b1;
                        mem_wdata = req_wdata[DATA_W-1:0];
                    end
                    if (req_half) begin
                        // Signedness is irrelevant for a full 16-bit result, so it is not kept.
                        stall      = 1'b1;
                        hi_addr_d  = req_addr + ADDR_W'(1);
                        hi_wdata_d = req_wdata[2*DATA_W-1:DATA_W];
                        hi_write_d = req_write;
                        lo_byte_d  = mem_rdata;
                        state_d    = StHi;
                    end else if (!req_write) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = extend_byte(mem_rdata, req_signed);
                    end
                end
            end
            StHi: begin
                // The pipeline still presents the same request; req_* are ignored here.
                mem_addr  = hi_addr_q;
                mem_write = hi_write_q;
                mem_wdata = hi_wdata_q;
                if (!hi_write_q) begin
                    ld_valid_d = 1'b1;
                    ld_data_d  = {mem_rdata, lo_byte_q};
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // No memory write may escape while reset is held, including a pending high byte.
        if (rst) begin
            mem_write = 1'b0;
        end
    end

    // State, halfword latches and registered load result; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_write_q <= 1'b0;
            lo_byte_q  <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hi_addr_q  <= hi_addr_d;
            hi_wdata_q <= hi_wdata_d;
            hi_write_q <= hi_write_d;
            lo_byte_q  <= lo_byte_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory and a load scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_half, req_signed;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        stall, ld_valid, mem_write;
    logic [15:0] ld_data;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [0:255];

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cycles  = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_half   (req_half),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at posedge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock, then compare any load result against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycles++;
        if (ld_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_ld_valid", {15'd0, ld_valid}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("ld_valid_cycle", 16'(cycles), 16'(e.due));
                check("ld_data", ld_data, e.data);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cycles) begin
            e = exp_q.pop_front();
            check("missing_ld_valid", {15'd0, ld_valid}, 16'd1);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic h, input logic s,
                         input logic [7:0] a, input logic [15:0] d);
        req_valid  = v;
        req_write  = w;
        req_half   = h;
        req_signed = s;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic expect_load(input logic [15:0] d, input int latency);
        exp_t e;
        e.data = d;
        e.due  = cycles + latency;
        exp_q.push_back(e);
    endtask

    task automatic byte_store(input logic [7:0] a, input logic [7:0] d);
        drive(1, 1, 0, 0, a, {8'h00, d});
        tick();
    endtask

    initial begin
        // Reset held with a store presented: no write, no load, no stall.
        rst = 1'b1;
        drive(1, 1, 0, 0, 8'h99, 16'h00EE);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_mem_write", {15'd0, mem_write}, 16'd0);
            check("rst_stall", {15'd0, stall}, 16'd0);
            tick();
            check("rst_ld_valid", {15'd0, ld_valid}, 16'd0);
            check("rst_ld_data", ld_data, 16'h0000);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h55, 16'h1234);
        #1;
        check("idle_mem_addr", {8'd0, mem_addr}, 16'h0000);
        check("idle_mem_write", {15'd0, mem_write}, 16'd0);
        tick();

        // Byte loads, signed then unsigned.
        byte_store(8'h10, 8'h85);
        check("mem10", {8'd0, mem[8'h10]}, 16'h0085);
        drive(1, 0, 0, 1, 8'h10, 16'h0000);
        expect_load(16'hFF85, 1);
        #1;
        check("byte_ld_stall", {15'd0, stall}, 16'd0);
        tick();
        drive(1, 0, 0, 0, 8'h10, 16'h0000);
        expect_load(16'h0085, 1);
        tick();

        // Half store 0xBEEF at 0x20, split into two beats.
        drive(1, 1, 1, 0, 8'h20, 16'hBEEF);
        #1;
        check("hs_lo_stall", {15'd0, stall}, 16'd1);
        check("hs_lo_addr", {8'd0, mem_addr}, 16'h0020);
        check("hs_lo_wdata", {8'd0, mem_wdata}, 16'h00EF);
        tick();
        check("mem20", {8'd0, mem[8'h20]}, 16'h00EF);
        check("hs_hi_stall", {15'd0, stall}, 16'd0);
        check("hs_hi_addr", {8'd0, mem_addr}, 16'h0021);
        check("hs_hi_write", {15'd0, mem_write}, 16'd1);
        tick();
        check("mem21", {8'd0, mem[8'h21]}, 16'h00BE);

        // Half load back, result two cycles after issue.
        drive(1, 0, 1, 1, 8'h20, 16'h0000);
        expect_load(16'hBEEF, 2);
        #1;
        check("hl_stall_n", {15'd0, stall}, 16'd1);
        tick();
        check("hl_stall_n1", {15'd0, stall}, 16'd0);
        tick();

        // Wrap-around half load at 0xFF.
        byte_store(8'hFF, 8'h34);
        byte_store(8'h00, 8'h12);
        drive(1, 0, 1, 0, 8'hFF, 16'h0000);
        expect_load(16'h1234, 2);
        #1;
        check("wrap_lo_addr", {8'd0, mem_addr}, 16'h00FF);
        tick();
        check("wrap_hi_addr", {8'd0, mem_addr}, 16'h0000);
        tick();

        // Store-then-load hazard, issued right after the HI cycle above.
        byte_store(8'h30, 8'h5A);
        drive(1, 0, 0, 1, 8'h30, 16'h0000);
        expect_load(16'h005A, 1);
        tick();

        // Reset during HI of a half store: low byte lands, high byte suppressed.
        byte_store(8'h41, 8'h77);
        drive(1, 1, 1, 0, 8'h40, 16'hABCD);
        tick();
        rst = 1'b1;
        #1;
        check("rst_hi_mem_write", {15'd0, mem_write}, 16'd0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 16'h0000);
        #1;
        check("mem40", {8'd0, mem[8'h40]}, 16'h00CD);
        check("mem41", {8'd0, mem[8'h41]}, 16'h0077);
        check("post_rst_idle_addr", {8'd0, mem_addr}, 16'h0000);
        check("post_rst_idle_stall", {15'd0, stall}, 16'd0);
        tick();

        // Reset during HI of a half load: no result may follow.
        drive(1, 0, 1, 0, 8'h20, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 16'h0000);
        tick();
        check("rst_hl_no_ld_valid", {15'd0, ld_valid}, 16'd0);

        // Reset coinciding with a byte load.
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'h10, 16'h0000);
        tick();
        check("rst_bl_ld_valid", {15'd0, ld_valid}, 16'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 16'h0000);
        tick();
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
